// File: rtl/md_unit_if.sv
// Handshake/result bundle between the EX stage and the multiply/divide unit.
// The flush signal exists only when MD_CANCEL_EN is defined.
interface md_unit_if;
  logic [3:0]  md_op;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
`ifdef MD_CANCEL_EN
  logic        flush;
`endif
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_out;

`ifdef MD_CANCEL_EN
  modport master (output md_op, start, A, B, flush, input busy, hi, lo, rd_out);
  modport slave  (input md_op, start, A, B, flush, output busy, hi, lo, rd_out);
`else
  modport master (output md_op, start, A, B, input busy, hi, lo, rd_out);
  modport slave  (input md_op, start, A, B, output busy, hi, lo, rd_out);
`endif
endinterface

// File: rtl/md_unit.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO, with fixed latency and busy flag.
// Optional MD_CANCEL_EN adds a flush input that cancels in-flight and same-cycle operations.
module md_unit #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic      clk,
  input  logic      rst_n,
  md_unit_if.slave  bus
);
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;
  localparam logic [3:0] OP_MFHI  = 4'b0111;
  localparam logic [3:0] OP_MFLO  = 4'b1000;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] hi_nx_q, hi_nx_d, lo_nx_q, lo_nx_d;
  logic        flush_w;

`ifdef MD_CANCEL_EN
  assign flush_w = bus.flush;
`else
  assign flush_w = 1'b0;
`endif

  // Arithmetic is evaluated on the start edge's operands and parked in staging.
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic        div_zero;

  assign prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
  assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};
  assign div_zero = (bus.B == 32'd0);

  // Signed divide via magnitudes so 0x80000000 / -1 wraps instead of overflowing.
  assign a_mag = bus.A[31] ? (32'd0 - bus.A) : bus.A;
  assign b_mag = bus.B[31] ? (32'd0 - bus.B) : bus.B;
  assign q_mag = div_zero ? 32'd0 : a_mag / b_mag;
  assign r_mag = div_zero ? 32'd0 : a_mag % b_mag;
  assign q_s   = (bus.A[31] ^ bus.B[31]) ? (32'd0 - q_mag) : q_mag;
  assign r_s   = bus.A[31] ? (32'd0 - r_mag) : r_mag;
  assign q_u   = div_zero ? 32'd0 : bus.A / bus.B;
  assign r_u   = div_zero ? 32'd0 : bus.A % bus.B;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      hi_nx_q <= 32'd0;
      lo_nx_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_nx_q <= hi_nx_d;
      lo_nx_q <= lo_nx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_nx_d = hi_nx_q;
    lo_nx_d = lo_nx_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !flush_w) begin
          case (bus.md_op)
            OP_MULT, OP_MULTU: begin
              hi_nx_d = (bus.md_op == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
              lo_nx_d = (bus.md_op == OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
              cnt_d   = 4'(MULT_LAT);
              busy_d  = 1'b1;
              state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero stages the current HI/LO so the commit is a no-op.
              if (div_zero) begin
                hi_nx_d = hi_q;
                lo_nx_d = lo_q;
              end else begin
                hi_nx_d = (bus.md_op == OP_DIV) ? r_s : r_u;
                lo_nx_d = (bus.md_op == OP_DIV) ? q_s : q_u;
              end
              cnt_d   = 4'(DIV_LAT);
              busy_d  = 1'b1;
              state_d = RUN;
            end
            OP_MTHI: hi_d = bus.A;
            OP_MTLO: lo_d = bus.A;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (flush_w) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = 4'd0;
          hi_nx_d = 32'd0;
          lo_nx_d = 32'd0;
        end else if (cnt_q == 4'd1) begin
          hi_d    = hi_nx_q;
          lo_d    = lo_nx_q;
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy   = busy_q;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
  assign bus.rd_out = (bus.md_op == OP_MFHI) ? hi_q :
                      (bus.md_op == OP_MFLO) ? lo_q : 32'd0;
endmodule
